// File: rtl/knight_rider_monitor_pkg.sv
// Shared definitions for the Knight Rider scanner monitor.
//   - LED bus geometry (NUM_LEDS, NUM_POS, POS_W)
//   - FSM state encoding
//   - valid scanner pattern table, indexed by position P
//   - decoder result struct
package knight_rider_monitor_pkg;

  localparam int NUM_LEDS = 8;
  localparam int NUM_POS  = 9;
  localparam int POS_W    = 4;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // PAT_TABLE[P] is the only legal LED image for position P.
  // The end positions light a single LED, the interior ones a pair.
  localparam logic [NUM_POS-1:0][NUM_LEDS-1:0] PAT_TABLE = {
    8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h01
  };

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] p;
  } dec_t;

endpackage

// File: rtl/knight_rider_monitor_if.sv
// Bus between the scanner under observation and the monitor.
//   led_in      : observed LED image (driven by master)
//   pos/dir     : decoded position and sweep direction (1 = toward LSB)
//   locked      : consistent sweep being tracked
//   step/err    : single-cycle event pulses
//   stall       : pattern frozen for too long
//   sweep_count : end reversals seen while locked (saturating)
interface knight_rider_monitor_if;
  import knight_rider_monitor_pkg::*;

  logic [NUM_LEDS-1:0] led_in;
  logic [POS_W-1:0]    pos;
  logic                dir;
  logic                locked;
  logic                step;
  logic                err;
  logic                stall;
  logic [15:0]         sweep_count;

  modport master (output led_in,
                  input  pos, dir, locked, step, err, stall, sweep_count);
  modport slave  (input  led_in,
                  output pos, dir, locked, step, err, stall, sweep_count);
endinterface

// File: rtl/knight_rider_pattern_decode.sv
// Combinational pattern decoder.
//   led_i : registered LED image
//   dec_o : {valid, P}; P is zero when the image is not a legal pattern
module knight_rider_pattern_decode
  import knight_rider_monitor_pkg::*;
(
  input  logic [NUM_LEDS-1:0] led_i,
  output dec_t                dec_o
);

  always_comb begin
    dec_o = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (led_i == PAT_TABLE[i]) begin
        dec_o.valid = 1'b1;
        dec_o.p     = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/knight_rider_monitor.sv
// Knight Rider scanner monitor.
// Registers the LED bus once, decodes it, and runs a HUNT/TRACK/LOCKED
// tracker over the decoded position. All outputs are registered, so an
// LED image appears on the outputs two clocks after it is presented.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of knight_rider_monitor_if
module knight_rider_monitor
  import knight_rider_monitor_pkg::*;
#(
  parameter int unsigned LOCK_STEPS  = 4,
  parameter logic [31:0] STALL_LIMIT = 32'd50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  knight_rider_monitor_if.slave bus
);

  logic [NUM_LEDS-1:0] led_q, led_prev_q;
  logic [1:0]          state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                dir_known_q, dir_known_d;
  logic                locked_q, locked_d;
  logic                step_q, step_d;
  logic                err_q, err_d;
  logic                stall_q, stall_d;
  logic [15:0]         sweep_q, sweep_d;
  logic [3:0]          steps_q, steps_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  dec_t dec;

  knight_rider_pattern_decode u_dec (
    .led_i (led_q),
    .dec_o (dec)
  );

  logic       changed, up, dn, cont, end_rev, legal, reversal;
  logic [4:0] steps_inc;

  // Motion is always judged against the registered position.
  assign changed  = (led_q != led_prev_q);
  assign up       = (dec.p == pos_q + 4'd1);
  assign dn       = (pos_q != '0) && (dec.p == pos_q - 4'd1);
  assign cont     = dir_q ? dn : up;
  assign end_rev  = ((pos_q == 4'd0) && (dec.p == 4'd1)) ||
                    ((pos_q == 4'd8) && (dec.p == 4'd7));
  assign legal    = (up || dn) && (!dir_known_q || cont || end_rev);
  assign reversal = dir_known_q && !cont && end_rev;
  assign steps_inc = (steps_q == 4'hF) ? 5'd15 : {1'b0, steps_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    dir_known_d = dir_known_q;
    locked_d    = locked_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    stall_d     = stall_q;
    sweep_d     = sweep_q;
    steps_d     = steps_q;
    stall_cnt_d = stall_cnt_q;

    if (!changed) begin
      // Frozen valid image: count towards a stall. Once the limit is hit
      // the tracker is held in HUNT until the image moves again.
      if (dec.valid) begin
        if (stall_cnt_q >= STALL_LIMIT - 32'd1) begin
          stall_cnt_d = STALL_LIMIT;
          stall_d     = 1'b1;
          locked_d    = 1'b0;
          state_d     = ST_HUNT;
        end else begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end
    end else begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
      if (state_q == ST_HUNT) begin
        if (dec.valid) begin
          state_d     = ST_TRACK;
          pos_d       = dec.p;
          steps_d     = '0;
          dir_known_d = 1'b0;
        end
      end else if (!dec.valid) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        state_d  = ST_HUNT;
      end else if (legal) begin
        step_d      = 1'b1;
        pos_d       = dec.p;
        dir_d       = dn;
        dir_known_d = 1'b1;
        steps_d     = steps_inc[3:0];
        if (state_q == ST_TRACK && steps_inc >= 5'(LOCK_STEPS)) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
        end
        if (state_q == ST_LOCKED && reversal && sweep_q != 16'hFFFF)
          sweep_d = sweep_q + 16'd1;
      end else begin
        // Jump or mid-range reversal: restart tracking from here.
        err_d       = 1'b1;
        state_d     = ST_TRACK;
        pos_d       = dec.p;
        steps_d     = '0;
        dir_known_d = 1'b0;
        locked_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      led_prev_q  <= '0;
      state_q     <= ST_HUNT;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      dir_known_q <= 1'b0;
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
      sweep_q     <= '0;
      steps_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      led_q       <= bus.led_in;
      led_prev_q  <= led_q;
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      dir_known_q <= dir_known_d;
      locked_q    <= locked_d;
      step_q      <= step_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      sweep_q     <= sweep_d;
      steps_q     <= steps_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pos         = pos_q;
  assign bus.dir         = dir_q;
  assign bus.locked      = locked_q;
  assign bus.step        = step_q;
  assign bus.err         = err_q;
  assign bus.stall       = stall_q;
  assign bus.sweep_count = sweep_q;

endmodule

// File: tb/tb_knight_rider_monitor.sv
module tb_knight_rider_monitor;
  localparam int LOCK  = 4;
  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knight_rider_monitor_if bus();

  knight_rider_monitor #(.LOCK_STEPS(LOCK), .STALL_LIMIT(32'(LIMIT))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: works per sampled LED image, one image per clock.
  int         m_state;            // 0 hunt, 1 track, 2 locked
  logic [7:0] m_cur, m_prev;      // image being judged, image before it
  int         m_n, m_idle;
  bit         m_dk;
  int         e_pos, e_sweep;
  bit         e_dir, e_step, e_err, e_stall;

  function automatic logic [7:0] enc(input int p);
    logic [7:0] v;
    if (p == 8)      v = 8'h80;
    else if (p == 0) v = 8'h01;
    else             v = 8'(8'h03 << (p - 1));
    return v;
  endfunction

  function automatic int to_pos(input logic [7:0] v);
    for (int p = 0; p <= 8; p++) if (enc(p) == v) return p;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] din);
    int p, d;
    bit turning, legal;
    e_step = 0; e_err = 0;
    if (r) begin
      m_state = 0; m_cur = 0; m_prev = 0; m_n = 0; m_idle = 0; m_dk = 0;
      e_pos = 0; e_sweep = 0; e_dir = 0; e_stall = 0;
      return;
    end
    p = to_pos(m_cur);
    if (m_cur == m_prev) begin
      if (p >= 0) begin
        if (m_idle < LIMIT) m_idle++;
        if (m_idle == LIMIT) begin e_stall = 1; m_state = 0; end
      end
    end else begin
      m_idle = 0; e_stall = 0;
      if (m_state == 0) begin
        if (p >= 0) begin m_state = 1; e_pos = p; m_n = 0; m_dk = 0; end
      end else if (p < 0) begin
        e_err = 1; m_state = 0;
      end else begin
        d = p - e_pos;
        turning = m_dk && ((d < 0) != e_dir);
        legal = (d == 1 || d == -1) && (!turning || e_pos == 0 || e_pos == 8);
        if (legal) begin
          e_step = 1;
          if (turning && m_state == 2 && e_sweep < 65535) e_sweep++;
          e_dir = (d < 0); m_dk = 1; e_pos = p;
          if (m_n < 15) m_n++;
          if (m_state == 1 && m_n >= LOCK) m_state = 2;
        end else begin
          e_err = 1; m_state = 1; e_pos = p; m_n = 0; m_dk = 0;
        end
      end
    end
    m_prev = m_cur;
    m_cur  = din;
  endtask

  task automatic tick(input logic r, input logic [7:0] v);
    @(negedge clk);
    rst = r;
    bus.led_in = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    chk("pos",    32'(bus.pos),         32'(e_pos));
    chk("dir",    32'(bus.dir),         32'(e_dir));
    chk("locked", 32'(bus.locked),      32'(m_state == 2));
    chk("step",   32'(bus.step),        32'(e_step));
    chk("err",    32'(bus.err),         32'(e_err));
    chk("stall",  32'(bus.stall),       32'(e_stall));
    chk("sweep",  32'(bus.sweep_count), 32'(e_sweep));
  endtask

  int cur_p   = 8;
  bit tb_down = 1;

  task automatic walk(input int n);
    repeat (n) begin
      if (cur_p == 0) tb_down = 0;
      if (cur_p == 8) tb_down = 1;
      cur_p = tb_down ? cur_p - 1 : cur_p + 1;
      tick(0, enc(cur_p));
    end
  endtask

  initial begin
    bus.led_in = 8'h00;
    repeat (3) tick(1, 8'h5A);
    chk("rst_pos", 32'(bus.pos), 0);
    chk("rst_locked", 32'(bus.locked), 0);

    // Lock-in from the MSB end.
    tick(0, 8'h80); tick(0, 8'hC0); tick(0, 8'h60); tick(0, 8'h30);
    tick(0, 8'h18); tick(0, 8'h18);
    chk("lock_pos", 32'(bus.pos), 4);
    chk("lock_dir", 32'(bus.dir), 1);
    chk("lock_step", 32'(bus.step), 1);
    chk("lock_locked", 32'(bus.locked), 1);

    // Reversal at the LSB end while locked.
    tick(0, 8'h0C); tick(0, 8'h06); tick(0, 8'h03); tick(0, 8'h01);
    tick(0, 8'h03); tick(0, 8'h06);
    chk("rev_sweep", 32'(bus.sweep_count), 1);
    chk("rev_dir", 32'(bus.dir), 0);

    // Invalid image while locked.
    tick(0, 8'h81); tick(0, 8'h81);
    chk("inv_err", 32'(bus.err), 1);
    chk("inv_locked", 32'(bus.locked), 0);
    chk("inv_pos", 32'(bus.pos), 2);
    tick(0, 8'h81);
    chk("inv_err_1cyc", 32'(bus.err), 0);

    // Jump and mid-range reversal while tracking.
    tick(0, 8'h18); tick(0, 8'hC0); tick(0, 8'hC0);
    chk("jump_err", 32'(bus.err), 1);
    chk("jump_pos", 32'(bus.pos), 7);
    tick(0, 8'h18); tick(0, 8'h30); tick(0, 8'h18); tick(0, 8'h18);
    chk("midrev_err", 32'(bus.err), 1);
    chk("midrev_pos", 32'(bus.pos), 4);
    chk("midrev_locked", 32'(bus.locked), 0);

    // Stall while locked at P=4.
    tick(0, 8'h0C); tick(0, 8'h06); tick(0, 8'h03); tick(0, 8'h01);
    tick(0, 8'h03); tick(0, 8'h06); tick(0, 8'h0C); tick(0, 8'h18);
    chk("pre_stall_locked", 32'(bus.locked), 1);
    repeat (24) tick(0, 8'h18);
    chk("stall_set", 32'(bus.stall), 1);
    chk("stall_locked", 32'(bus.locked), 0);
    tick(0, 8'h0C); tick(0, 8'h0C);
    chk("stall_clr", 32'(bus.stall), 0);

    // Five sweeps, then reset mid-sweep and relock.
    tick(1, 8'h00);
    cur_p = 8; tb_down = 1;
    tick(0, enc(8));
    walk(44);
    chk("sweep5", 32'(bus.sweep_count), 5);
    tick(1, enc(cur_p));
    chk("rst2_sweep", 32'(bus.sweep_count), 0);
    chk("rst2_pos", 32'(bus.pos), 0);
    cur_p = 8; tb_down = 1;
    tick(0, enc(8));
    walk(4);
    chk("relock_3", 32'(bus.locked), 0);
    walk(1);
    chk("relock_4", 32'(bus.locked), 1);

    // Randomized mix of legal motion, holds, glitches and jumps.
    for (int i = 0; i < 500; i++) begin
      int a;
      a = int'($urandom_range(0, 99));
      if (a < 1) begin
        tick(1, 8'h00);
      end else if (a < 68) begin
        walk(1);
      end else if (a < 76) begin
        repeat ($urandom_range(1, 20)) tick(0, enc(cur_p));
      end else if (a < 84) begin
        tick(0, 8'($urandom));
      end else if (a < 92) begin
        cur_p = int'($urandom_range(0, 8));
        tick(0, enc(cur_p));
      end else begin
        tb_down = !tb_down;
        walk(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/knight_rider_monitor.md
KNIGHT_RIDER_MONITOR -- requirements
Module: knight_rider_monitor

Interface
REQ-001 Parameter LOCK_STEPS, default 4, is the number of consecutive legal steps needed to declare lock (range 1..15).
REQ-002 Parameter STALL_LIMIT, default 50_000_000, is the number of cycles without a pattern change before a stall is flagged (32-bit).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 led_in  input  8  observed scanner LED bus, same clock domain.
REQ-007 pos  output  4  decoded scanner position P, 0..8.
REQ-008 dir  output  1  1 = moving toward LSB (P decreasing), 0 = toward MSB.
REQ-009 locked  output  1  high while tracking a consistent sweep.
REQ-010 step  output  1  one-cycle pulse on each legal step.
REQ-011 err  output  1  one-cycle pulse on any protocol violation.
REQ-012 stall  output  1  level, high while no change for at least STALL_LIMIT cycles.
REQ-013 sweep_count  output  16  number of legal end reversals while locked, saturating.

Function
REQ-014 led_in SHALL be registered once (led_q); decode and state update use led_q; outputs are registered, giving 2-cycle latency from led_in to outputs.
REQ-015 Valid patterns: P=8 -> 0x80; P=1..7 -> LEDs P and P-1 lit only; P=0 -> 0x01. All other values, including 0x00, are invalid.
REQ-016 FSM states: HUNT, TRACK, LOCKED.
REQ-017 HUNT: a valid pattern -> TRACK; pos = P; step count = 0. Invalid -> stay; no err.
REQ-018 Step = valid pattern with P_new = P_old ± 1.
- First step after entering TRACK sets dir.
- Later steps are legal if they continue dir, or reverse only from P=0 to 1 or from P=8 to 7.
REQ-019 A legal step SHALL pulse step, update pos/dir, and increment the step count.
- In TRACK, the count reaching LOCK_STEPS -> LOCKED, with locked high in the same cycle as that step pulse.
REQ-020 A legal end reversal in LOCKED SHALL increment sweep_count, saturating at 0xFFFF.
REQ-021 An invalid pattern in TRACK/LOCKED SHALL pulse err and go to HUNT; locked drops with the err pulse.
REQ-022 A valid pattern with |ΔP|>1, or an illegal mid-range reversal, in TRACK/LOCKED SHALL pulse err, go to TRACK, set pos = P_new, and clear the step count and direction knowledge.
REQ-023 An unchanged valid pattern SHALL increment the stall counter.
- Any pattern change clears the counter and stall.
- Counter reaching STALL_LIMIT sets stall, clears locked and goes to HUNT, without err.
- Counter saturates.
REQ-024 The direction of a legal step SHALL be decided against the registered pos, never against the raw input.
REQ-025 pos SHALL hold its last value in HUNT.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL apply on the next cycle, regardless of state or mid-operation:
- led_q=0, pos=0, dir=0, locked=0, step=0, err=0, stall=0, sweep_count=0.
- Stall counter=0, step count=0, state=HUNT.
REQ-027 Reset SHALL dominate all other events in the same cycle.

Structure
REQ-028 A shared package SHALL hold:
- NUM_LEDS=8, NUM_POS=9 and POS_W=4;
- the FSM state encoding;
- the valid-pattern table constants.
REQ-029 One combinational sub-module, knight_rider_pattern_decode, SHALL map 8-bit led_q to {valid, P[3:0]}; the FSM, counters and output registers stay in the top.

Verification
REQ-030 Reset, then feed 0x80,0xC0,0x60,0x30,0x18, each held 1 cycle.
- Required: pos 8,7,6,5,4; dir=1; step pulses x4; locked=1 with the 4th step.
REQ-031 Locked sweep ...0x03,0x01,0x03,0x06.
- Required: no err; dir 1->0 at the 0x03 after 0x01; sweep_count increments 0->1.
REQ-032 Locked, then apply 0x81.
- Required: err pulses exactly 1 cycle; locked=0; state HUNT; pos holds the last value.
REQ-033 Tracking at 0x18 (P=4), then apply 0xC0 (P=7), and separately 0x18->0x30->0x18.
- Required: err pulse each time; state TRACK; pos = new P; locked=0; step count restarts.
REQ-034 STALL_LIMIT=16: hold 0x18 while locked.
- Required: stall=1 and locked=0 after 16 unchanged cycles; the next change clears stall.
REQ-035 Assert rst mid-sweep with sweep_count=5.
- Required: all outputs zero next cycle; relock requires LOCK_STEPS fresh steps.
